regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32: number of architectural registers, 5-bit indices.
REQ-002 SHALL have parameter MAX_PENDING, default 8: maximum outstanding register writes.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port issue_valid, input, 1: decoded instruction presented for issue.
REQ-006 SHALL have port issue_ready, output, 1: issue accepted this cycle when issue_valid is high.
REQ-007 SHALL have ports issue_rs1 / issue_rs2, input, 5 each: source register indices.
REQ-008 SHALL have ports issue_rs1_en / issue_rs2_en, input, 1 each: source operand used.
REQ-009 SHALL have ports issue_rd, input, 5, and issue_rd_en, input, 1: destination register and write intent.
REQ-010 SHALL have ports wb_valid, input, 1, and wb_rd, input, 5: register-file write occurring this cycle.
REQ-011 SHALL have port flush, input, 1: discard all outstanding writes.
REQ-012 SHALL have port drain_req, input, 1: request pipeline drain.
REQ-013 SHALL have port drain_done, output, 1: one-cycle pulse; drain complete.
REQ-014 SHALL have port stall, output, 1: issue_valid && !issue_ready.
REQ-015 SHALL have port busy_mask, output, NUM_REGS: bit i set = write to xi outstanding.
REQ-016 SHALL have port pending_cnt, output, 4: count of outstanding writes.
REQ-017 SHALL have port wb_err, output, 1: registered pulse; writeback to a non-busy register or x0.

Function
REQ-018 SHALL set busy_mask[0] to 0 at all times; issue with rd=0 SHALL NOT set a busy bit or increment pending_cnt.
REQ-019 SHALL define a source hazard as rsN_en && busy_mask[rsN] && !(wb_valid && wb_rd==rsN); the same-cycle writeback is forwarded by the register file.
REQ-020 SHALL define a WAW hazard as rd_en && rd!=0 && busy_mask[rd] && !(wb_valid && wb_rd==rd).
REQ-021 SHALL drive issue_ready = (state==RUN) && !flush && no source hazard && no WAW hazard && pending_cnt<MAX_PENDING; this path SHALL be combinational.
REQ-022 SHALL, on an issue fire (issue_valid && issue_ready) with rd_en and rd!=0, set busy_mask[rd] and increment pending_cnt at the next edge.
REQ-023 SHALL, on wb_valid with busy_mask[wb_rd]==1, clear that bit and decrement pending_cnt at the next edge.
REQ-024 SHALL treat wb_valid with busy_mask[wb_rd]==0 or wb_rd==0 as no-op on state and assert wb_err for the following cycle.
REQ-025 SHALL, when an issue sets and a writeback clears the same rd in one cycle, leave the bit set and pending_cnt unchanged.
REQ-026 SHALL, when an issue and a writeback hit different registers in one cycle, apply both, leaving pending_cnt unchanged.
REQ-027 SHALL have FSM states RUN, DRAIN, DONE.
REQ-028 SHALL move RUN->DRAIN on drain_req; DRAIN->DONE on the edge where pending_cnt==0 (including post-writeback value); DONE->RUN unconditionally.
REQ-029 SHALL assert drain_done exactly while in DONE (one cycle); issue_ready SHALL be 0 in DRAIN and DONE.
REQ-030 SHALL ignore drain_req outside RUN.
REQ-031 SHALL, on flush, clear busy_mask and pending_cnt and force state RUN at the next edge; flush SHALL take priority over same-cycle issue, writeback and drain_req; wb_err SHALL NOT assert for writebacks in the flush cycle.

Reset
REQ-032 SHALL, when rst is high at a clock edge, set busy_mask=0, pending_cnt=0, state=RUN, drain_done=0 and wb_err=0, overriding all other inputs.
REQ-033 SHALL, after reset mid-operation, drop all outstanding writes; later writebacks to those registers SHALL raise wb_err.

Verification
REQ-034 SHALL cover: issue rd=5; next cycle issue rs1=5 -> issue_ready=0, stall=1; wb_rd=5 that cycle -> issue_ready=1 (forwarded); busy_mask[5]=0 next cycle.
REQ-035 SHALL cover: issue rd=0 with rd_en=1 -> busy_mask stays 0, pending_cnt stays 0; wb_rd=0 -> wb_err=1 next cycle.
REQ-036 SHALL cover: 8 issues to x1..x8 -> pending_cnt=8; 9th issue (rd=9, no hazard) -> issue_ready=0; one writeback -> ready next cycle.
REQ-037 SHALL cover: pending_cnt=2, drain_req -> DRAIN, issue_ready=0; two writebacks -> drain_done pulses one cycle after pending reaches 0, then RUN.
REQ-038 SHALL cover: busy x3,x4; flush with simultaneous issue rd=6 and wb_rd=3 -> busy_mask=0, pending_cnt=0, no wb_err.
REQ-039 SHALL cover: same cycle issue rd=7 and wb_rd=7 (busy) -> busy_mask[7]=1, pending_cnt unchanged.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register-file scoreboard: tracks outstanding destination writes, blocks issue
// on RAW/WAW hazards or a full write window, and sequences pipeline drain.
module regfile_scoreboard #(
  parameter int unsigned NUM_REGS    = 32,
  parameter int unsigned MAX_PENDING = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [4:0]          issue_rs1,
  input  logic [4:0]          issue_rs2,
  input  logic                issue_rs1_en,
  input  logic                issue_rs2_en,
  input  logic [4:0]          issue_rd,
  input  logic                issue_rd_en,
  input  logic                wb_valid,
  input  logic [4:0]          wb_rd,
  input  logic                flush,
  input  logic                drain_req,
  output logic                drain_done,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [3:0]          pending_cnt,
  output logic                wb_err
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PENDING);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t              state, state_d;
  logic [NUM_REGS-1:0] busy_d;
  logic [CNT_W-1:0]    cnt_d;
  logic                drain_done_d;
  logic                wb_err_d;

  logic src1_haz, src2_haz, waw_haz;
  logic wb_clr, iss_set;

  // A same-cycle writeback to a source or destination resolves the hazard.
  assign src1_haz = issue_rs1_en && busy_mask[issue_rs1] && !(wb_valid && wb_rd == issue_rs1);
  assign src2_haz = issue_rs2_en && busy_mask[issue_rs2] && !(wb_valid && wb_rd == issue_rs2);
  assign waw_haz  = issue_rd_en && (issue_rd != 5'd0) && busy_mask[issue_rd]
                    && !(wb_valid && wb_rd == issue_rd);

  assign issue_ready = (state == RUN) && !flush && !src1_haz && !src2_haz && !waw_haz
                       && (pending_cnt < MAX_CNT);
  assign stall       = issue_valid && !issue_ready;

  assign wb_clr  = wb_valid && (wb_rd != 5'd0) && busy_mask[wb_rd];
  assign iss_set = issue_valid && issue_ready && issue_rd_en && (issue_rd != 5'd0);

  // Next-state, busy tracking and pulse outputs; flush overrides everything.
  always_comb begin
    state_d      = state;
    busy_d       = busy_mask;
    cnt_d        = pending_cnt;
    wb_err_d     = 1'b0;
    drain_done_d = 1'b0;

    if (flush) begin
      busy_d  = '0;
      cnt_d   = '0;
      state_d = RUN;
    end else begin
      wb_err_d = wb_valid && !wb_clr;
      // Clear before set so an issue and writeback to the same rd leaves it busy.
      if (wb_clr)  busy_d[wb_rd]    = 1'b0;
      if (iss_set) busy_d[issue_rd] = 1'b1;
      cnt_d = pending_cnt + CNT_W'(iss_set) - CNT_W'(wb_clr);

      case (state)
        RUN:     if (drain_req) state_d = DRAIN;
        DRAIN:   if (cnt_d == '0) state_d = DONE;
        DONE:    state_d = RUN;
        default: state_d = RUN;
      endcase
      drain_done_d = (state_d == DONE);
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      busy_mask   <= '0;
      pending_cnt <= '0;
      drain_done  <= 1'b0;
      wb_err      <= 1'b0;
    end else begin
      state       <= state_d;
      busy_mask   <= busy_d;
      pending_cnt <= cnt_d;
      drain_done  <= drain_done_d;
      wb_err      <= wb_err_d;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios plus random traffic against
// a register-set reference model.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd, wb_rd;
  logic        issue_rs1_en, issue_rs2_en, issue_rd_en;
  logic        wb_valid, flush, drain_req;
  logic        drain_done, stall, wb_err;
  logic [31:0] busy_mask;
  logic [3:0]  pending_cnt;

  int checks   = 0;
  int failures = 0;

  regfile_scoreboard #(.NUM_REGS(32), .MAX_PENDING(8)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs1_en(issue_rs1_en), .issue_rs2_en(issue_rs2_en),
    .issue_rd(issue_rd), .issue_rd_en(issue_rd_en),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .flush(flush), .drain_req(drain_req), .drain_done(drain_done),
    .stall(stall), .busy_mask(busy_mask), .pending_cnt(pending_cnt), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic idle();
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rs1_en = 0; issue_rs2_en = 0;
    issue_rd = 0; issue_rd_en = 0; wb_valid = 0; wb_rd = 0; flush = 0; drain_req = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    idle(); issue_valid = 1; issue_rd = rd; issue_rd_en = 1;
  endtask

  task automatic test_reset();
    idle(); rst = 1; tick(); tick(); rst = 0; #1;
    checks++; if (busy_mask !== 32'h0) begin failures++; $display("FAIL reset_busy got=%h exp=0", busy_mask); end
    checks++; if (pending_cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", pending_cnt); end
    checks++; if (drain_done !== 1'b0 || wb_err !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b exp=00", drain_done, wb_err); end
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", issue_ready); end
  endtask

  task automatic test_raw_forward();
    issue(5); tick();
    checks++; if (busy_mask !== 32'h20) begin failures++; $display("FAIL raw_busy got=%h exp=20", busy_mask); end
    idle(); issue_valid = 1; issue_rs1 = 5; issue_rs1_en = 1; #1;
    checks++; if (issue_ready !== 1'b0 || stall !== 1'b1) begin failures++; $display("FAIL raw_stall got=%b%b exp=01", issue_ready, stall); end
    wb_valid = 1; wb_rd = 5; #1;
    checks++; if (issue_ready !== 1'b1 || stall !== 1'b0) begin failures++; $display("FAIL raw_fwd got=%b%b exp=10", issue_ready, stall); end
    tick();
    checks++; if (busy_mask !== 32'h0 || pending_cnt !== 4'd0 || wb_err !== 1'b0) begin failures++; $display("FAIL raw_clear got=%h/%0d/%b exp=0/0/0", busy_mask, pending_cnt, wb_err); end
  endtask

  task automatic test_x0();
    issue(0); tick();
    checks++; if (busy_mask !== 32'h0 || pending_cnt !== 4'd0) begin failures++; $display("FAIL x0_issue got=%h/%0d exp=0/0", busy_mask, pending_cnt); end
    idle(); wb_valid = 1; wb_rd = 0; tick();
    checks++; if (wb_err !== 1'b1) begin failures++; $display("FAIL x0_wb_err got=%b exp=1", wb_err); end
    idle(); tick();
    checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL x0_wb_err_pulse got=%b exp=0", wb_err); end
  endtask

  task automatic test_max_pending();
    for (int i = 1; i <= 8; i++) begin issue(5'(i)); tick(); end
    checks++; if (pending_cnt !== 4'd8 || busy_mask !== 32'h1FE) begin failures++; $display("FAIL max_fill got=%0d/%h exp=8/1fe", pending_cnt, busy_mask); end
    issue(9); #1;
    checks++; if (issue_ready !== 1'b0 || stall !== 1'b1) begin failures++; $display("FAIL max_block got=%b%b exp=01", issue_ready, stall); end
    wb_valid = 1; wb_rd = 1; tick();
    wb_valid = 0;
    checks++; if (pending_cnt !== 4'd7 || issue_ready !== 1'b1) begin failures++; $display("FAIL max_release got=%0d/%b exp=7/1", pending_cnt, issue_ready); end
    tick();
    checks++; if (pending_cnt !== 4'd8 || busy_mask !== 32'h3FC) begin failures++; $display("FAIL max_refill got=%0d/%h exp=8/3fc", pending_cnt, busy_mask); end
    idle(); flush = 1; tick(); idle();
    checks++; if (busy_mask !== 32'h0 || pending_cnt !== 4'd0) begin failures++; $display("FAIL max_flush got=%h/%0d exp=0/0", busy_mask, pending_cnt); end
  endtask

  task automatic test_drain();
    issue(10); tick(); issue(11); tick();
    idle(); drain_req = 1; tick(); idle();
    issue_valid = 1; issue_rd = 12; issue_rd_en = 1; #1;
    checks++; if (issue_ready !== 1'b0 || stall !== 1'b1 || drain_done !== 1'b0) begin failures++; $display("FAIL drain_block got=%b%b%b exp=010", issue_ready, stall, drain_done); end
    idle(); wb_valid = 1; wb_rd = 10; tick();
    checks++; if (pending_cnt !== 4'd1 || drain_done !== 1'b0) begin failures++; $display("FAIL drain_mid got=%0d/%b exp=1/0", pending_cnt, drain_done); end
    wb_rd = 11; tick(); idle(); #1;
    checks++; if (pending_cnt !== 4'd0 || drain_done !== 1'b1 || issue_ready !== 1'b0) begin failures++; $display("FAIL drain_done got=%0d/%b/%b exp=0/1/0", pending_cnt, drain_done, issue_ready); end
    tick();
    checks++; if (drain_done !== 1'b0 || issue_ready !== 1'b1) begin failures++; $display("FAIL drain_run got=%b/%b exp=0/1", drain_done, issue_ready); end
  endtask

  task automatic test_flush();
    issue(3); tick(); issue(4); tick();
    issue(6); wb_valid = 1; wb_rd = 3; flush = 1; #1;
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", issue_ready); end
    tick(); idle();
    checks++; if (busy_mask !== 32'h0 || pending_cnt !== 4'd0 || wb_err !== 1'b0) begin failures++; $display("FAIL flush_state got=%h/%0d/%b exp=0/0/0", busy_mask, pending_cnt, wb_err); end
  endtask

  task automatic test_same_rd();
    issue(7); tick();
    issue(7); wb_valid = 1; wb_rd = 7; #1;
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL same_rd_ready got=%b exp=1", issue_ready); end
    tick(); idle();
    checks++; if (busy_mask !== 32'h80 || pending_cnt !== 4'd1) begin failures++; $display("FAIL same_rd got=%h/%0d exp=80/1", busy_mask, pending_cnt); end
    wb_valid = 1; wb_rd = 7; tick(); idle();
  endtask

  task automatic test_reset_mid();
    issue(2); tick(); idle(); rst = 1; tick(); rst = 0;
    checks++; if (busy_mask !== 32'h0 || pending_cnt !== 4'd0) begin failures++; $display("FAIL rstmid_state got=%h/%0d exp=0/0", busy_mask, pending_cnt); end
    wb_valid = 1; wb_rd = 2; tick(); idle();
    checks++; if (wb_err !== 1'b1) begin failures++; $display("FAIL rstmid_wb_err got=%b exp=1", wb_err); end
    tick();
  endtask

  // Reference: the set of outstanding destinations plus a run/drain/done mode.
  task automatic test_random();
    logic [31:0] mb = 32'h0;
    int mode = 0;
    logic exp_done = 0, exp_err = 0, exp_ready, clr;
    int n;
    for (int c = 0; c < 400; c++) begin
      idle();
      issue_valid  = ($urandom_range(0, 9) < 7);
      issue_rs1    = 5'($urandom_range(0, 11)); issue_rs1_en = 1'($urandom);
      issue_rs2    = 5'($urandom_range(0, 11)); issue_rs2_en = 1'($urandom);
      issue_rd     = 5'($urandom_range(0, 11)); issue_rd_en  = ($urandom_range(0, 3) != 0);
      wb_valid     = ($urandom_range(0, 9) < 5);
      wb_rd        = 5'($urandom_range(0, 11));
      if (mb != 0 && $urandom_range(0, 3) != 0)
        for (int t = 0; t < 16 && !mb[wb_rd]; t++) wb_rd = 5'($urandom_range(1, 11));
      flush        = ($urandom_range(0, 39) == 0);
      drain_req    = ($urandom_range(0, 19) == 0);
      n = $countones(mb);
      exp_ready = (mode == 0) && !flush && (n < 8)
        && !(issue_rs1_en && mb[issue_rs1] && !(wb_valid && wb_rd == issue_rs1))
        && !(issue_rs2_en && mb[issue_rs2] && !(wb_valid && wb_rd == issue_rs2))
        && !(issue_rd_en && issue_rd != 0 && mb[issue_rd] && !(wb_valid && wb_rd == issue_rd));
      #1;
      checks++; if (issue_ready !== exp_ready || stall !== (issue_valid && !exp_ready)) begin
        failures++; $display("FAIL rand_ready cyc=%0d got=%b%b exp=%b%b", c, issue_ready, stall, exp_ready, issue_valid && !exp_ready); end
      tick();
      if (flush) begin
        mb = 0; mode = 0; exp_err = 0; exp_done = 0;
      end else begin
        clr = wb_valid && wb_rd != 0 && mb[wb_rd];
        exp_err = wb_valid && !clr;
        if (clr) mb[wb_rd] = 0;
        if (issue_valid && exp_ready && issue_rd_en && issue_rd != 0) mb[issue_rd] = 1;
        if (mode == 0) mode = drain_req ? 1 : 0;
        else if (mode == 1) mode = (mb == 0) ? 2 : 1;
        else mode = 0;
        exp_done = (mode == 2);
      end
      checks++; if (busy_mask !== mb || pending_cnt !== 4'($countones(mb))) begin
        failures++; $display("FAIL rand_state cyc=%0d got=%h/%0d exp=%h/%0d", c, busy_mask, pending_cnt, mb, $countones(mb)); end
      checks++; if (drain_done !== exp_done || wb_err !== exp_err) begin
        failures++; $display("FAIL rand_pulses cyc=%0d got=%b%b exp=%b%b", c, drain_done, wb_err, exp_done, exp_err); end
    end
    idle();
  endtask

  initial begin
    idle(); rst = 1;
    test_reset();
    test_raw_forward();
    test_x0();
    test_max_pending();
    test_drain();
    test_flush();
    test_same_rd();
    test_reset_mid();
    rst = 1; tick(); rst = 0;
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
